// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction fetch (if_*) and load/store (d_*).
// Latency: read = MEM_LAT+2 cycles from req-sampled cycle to rvalid; a store reaches memory 1 cycle after sampling.
// Backpressure: one transaction at a time; req must be held until gnt, and req is ignored outside IDLE.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (always a read)
//   if_gnt/if_rvalid/if_rdata     fetch accept pulse, read-data valid pulse, held fetched word
//   d_req/d_we/d_addr/d_wdata     load/store request
//   d_gnt/d_rvalid/d_rdata        data accept pulse, load-data valid pulse, held loaded word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   shared RAM interface
//   busy                          high whenever the FSM is not in IDLE
//
// Optional feature: define ARB_FAIRNESS_EN to force a fetch win after STARVE_MAX
// consecutive data wins that had a competing fetch. Without it, data always beats fetch.
module mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // The latency counter and the fairness counter are both 3 bits wide.
   if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
      $error("mem_arbiter: MEM_LAT and STARVE_MAX must be in 1..7");
   end

   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t     state, state_nxt;
   logic       own_d;      // owner of the latched transaction: 1 = data port, 0 = fetch
   logic       lat_we;
   logic [2:0] cnt;
   logic       take;       // accept a request this cycle (IDLE only)
   logic       pick_d;     // data port wins this arbitration
   logic       capture;    // last WAIT cycle: mem_rdata is valid
   logic       force_if;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      pick_d    = 1'b0;
      capture   = 1'b0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               take      = 1'b1;
               pick_d    = d_req && !force_if;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            if_gnt    = !own_d;
            d_gnt     = own_d;
            state_nxt = lat_we ? IDLE : WAIT;
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_d     <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cnt       <= 3'd0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         // rvalid is the registered capture strobe, so it lands on the following IDLE cycle.
         if_rvalid <= capture && !own_d;
         d_rvalid  <= capture && own_d;
         if (take) begin
            own_d    <= pick_d;
            lat_we   <= pick_d && d_we;
            mem_addr <= pick_d ? d_addr : if_addr;
            // A fetch has no write data; keep the last store data on the bus.
            if (pick_d) mem_wdata <= d_wdata;
         end
         if (state == ISSUE)
            cnt <= LAT_M1;
         else if (state == WAIT && cnt != 3'd0)
            cnt <= cnt - 3'd1;
         if (capture) begin
            if (own_d) d_rdata  <= mem_rdata;
            else       if_rdata <= mem_rdata;
         end
      end
   end

`ifdef ARB_FAIRNESS_EN
   // Counts data wins that starved a pending fetch; at STARVE_MAX the next contested slot goes to fetch.
   logic [2:0] starve_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 3'd0;
      end else if (take) begin
         if (!pick_d)     starve_cnt <= 3'd0;
         else if (if_req) starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign force_if = if_req && (starve_cnt == 3'(STARVE_MAX));
`else
   assign force_if = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter, checked against a transaction-level model.
// Latency: model schedules gnt/mem access/rvalid by cycle arithmetic from each accepted request.
// Backpressure: requesters hold req until the model's predicted gnt, then may issue again.
module tb_mem_arbiter;

   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int MEM_LAT    = 3;
   localparam int STARVE_MAX = 4;
   localparam int NC         = 4096;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_gnt, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Environment RAM: synchronous read with MEM_LAT cycles from issue to data.
   logic [DATA_W-1:0] ram [1 << ADDR_W];
   logic [DATA_W-1:0] pipe [MEM_LAT];
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      pipe[0] <= ram[mem_addr];
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[MEM_LAT-1];

   // Reference model state: expected events per cycle.
   logic [DATA_W-1:0] model_mem [1 << ADDR_W];
   bit                e_if_gnt [NC];
   bit                e_d_gnt  [NC];
   bit                e_mem_en [NC];
   bit                e_mem_we [NC];
   bit                e_if_rv  [NC];
   bit                e_d_rv   [NC];
   logic [ADDR_W-1:0] e_addr   [NC];
   logic [DATA_W-1:0] e_wdata  [NC];
   logic [DATA_W-1:0] e_if_dat [NC];
   logic [DATA_W-1:0] e_d_dat  [NC];
   int                free_at = 0;   // first cycle in which a new request may be accepted
   logic [ADDR_W-1:0] h_addr = '0;
   logic [DATA_W-1:0] h_if   = '0;
   logic [DATA_W-1:0] h_d    = '0;
`ifdef ARB_FAIRNESS_EN
   int                losses = 0;
`endif

   // Requester state
   int                cyc = 0;
   int                mode = 0;      // 0 directed only, 1 random, 2 both ports saturated
   bit                if_act = 0, d_act = 0, d_st = 0;
   logic [ADDR_W-1:0] if_a = '0, d_a = '0;
   logic [DATA_W-1:0] d_w = '0;
   int                obs_if = 0, obs_d = 0;
   int                n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_cycle();
      chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt[cyc]));
      chk("d_gnt",     32'(d_gnt),     32'(e_d_gnt[cyc]));
      chk("mem_en",    32'(mem_en),    32'(e_mem_en[cyc]));
      chk("mem_we",    32'(mem_we),    32'(e_mem_we[cyc]));
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv[cyc]));
      chk("d_rvalid",  32'(d_rvalid),  32'(e_d_rv[cyc]));
      chk("busy",      32'(busy),      32'(cyc < free_at));
      if (e_mem_en[cyc]) h_addr = e_addr[cyc];
      chk("mem_addr", 32'(mem_addr), 32'(h_addr));
      if (e_mem_we[cyc]) chk("mem_wdata", mem_wdata, e_wdata[cyc]);
      if (e_if_rv[cyc]) h_if = e_if_dat[cyc];
      if (e_d_rv[cyc])  h_d  = e_d_dat[cyc];
      chk("if_rdata", if_rdata, h_if);
      chk("d_rdata",  d_rdata,  h_d);
   endtask

   // Arbitration rule applied to this cycle's inputs: one transaction at a time,
   // data first, store occupies 2 cycles, read occupies MEM_LAT+2 cycles.
   task automatic model_arb();
      bit                win_d;
      int                t;
      logic [ADDR_W-1:0] a;
      if (cyc < free_at || !(if_req || d_req)) return;
      win_d = d_req;
`ifdef ARB_FAIRNESS_EN
      if (if_req && losses == STARVE_MAX) win_d = 0;
      if (!win_d)      losses = 0;
      else if (if_req) losses++;
`endif
      a = win_d ? d_addr : if_addr;
      e_mem_en[cyc+1] = 1;
      e_addr[cyc+1]   = a;
      if (win_d) e_d_gnt[cyc+1] = 1;
      else       e_if_gnt[cyc+1] = 1;
      if (win_d && d_we) begin
         e_mem_we[cyc+1] = 1;
         e_wdata[cyc+1]  = d_wdata;
         model_mem[a]    = d_wdata;
         free_at         = cyc + 2;
      end else begin
         t = cyc + MEM_LAT + 2;
         if (win_d) begin e_d_rv[t] = 1;  e_d_dat[t] = model_mem[a];  end
         else       begin e_if_rv[t] = 1; e_if_dat[t] = model_mem[a]; end
         free_at = t;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (e_if_gnt[cyc-1]) if_act = 0;
      if (e_d_gnt[cyc-1])  d_act  = 0;
      if (!if_act && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))) begin
         if_act = 1;
         if_a   = ADDR_W'($urandom_range(0, 15));
      end
      if (!d_act && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))) begin
         d_act = 1;
         d_a   = ADDR_W'($urandom_range(0, 15));
         d_w   = $urandom;
         d_st  = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if_req  = if_act;
      if_addr = if_act ? if_a : ADDR_W'($urandom);
      d_req   = d_act;
      d_we    = d_act ? d_st : 1'($urandom);
      d_addr  = d_act ? d_a : ADDR_W'($urandom);
      d_wdata = d_act ? d_w : $urandom;
      @(negedge clk);
      check_cycle();
      if (mode == 2) begin
         obs_if += int'(if_gnt);
         obs_d  += int'(d_gnt);
      end
      if (!rst) model_arb();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_if(input logic [ADDR_W-1:0] a);
      if_act = 1; if_a = a;
   endtask

   task automatic start_d(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
      d_act = 1; d_st = we; d_a = a; d_w = w;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         ram[i]       = $urandom;
         model_mem[i] = ram[i];
      end
      ram[4]       = 32'h2002_0005;
      model_mem[4] = 32'h2002_0005;

      // Reset state
      run(2);
      rst = 1'b0;
      run(2);

      // Single fetch
      start_if(10'd4);
      run(8);
      chk("fetch4_data", if_rdata, 32'h2002_0005);

      // Simultaneous store + fetch: store goes first
      start_d(1'b1, 10'h10, 32'hDEAD_BEEF);
      start_if(10'd5);
      run(10);

      // Load back the stored word
      start_d(1'b0, 10'h10, 32'h0);
      run(8);
      chk("ld10_data", d_rdata, 32'hDEAD_BEEF);

      // Reset during WAIT of a load
      start_d(1'b0, 10'd4, 32'h0);
      run(3);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_mem_en",    32'(mem_en),    32'h0);
      chk("rst_mem_addr",  32'(mem_addr),  32'h0);
      chk("rst_mem_wdata", mem_wdata,      32'h0);
      chk("rst_d_gnt",     32'(d_gnt),     32'h0);
      chk("rst_d_rdata",   d_rdata,        32'h0);
      chk("rst_if_rdata",  if_rdata,       32'h0);
      for (int i = cyc + 1; i < cyc + 16; i++) begin
         e_if_gnt[i] = 0; e_d_gnt[i] = 0; e_mem_en[i] = 0;
         e_mem_we[i] = 0; e_if_rv[i] = 0; e_d_rv[i]  = 0;
      end
      free_at = 0; h_addr = '0; h_if = '0; h_d = '0;
      if_act = 0; d_act = 0;
`ifdef ARB_FAIRNESS_EN
      losses = 0;
`endif
      step();
      rst = 1'b0;
      run(2);
      start_if(10'd4);
      run(8);
      chk("post_rst_fetch", if_rdata, 32'h2002_0005);
      chk("post_rst_d_rdata", d_rdata, 32'h0);

      // Both ports requesting continuously for 20 cycles
      mode = 2;
      run(20);
      mode = 0;
`ifdef ARB_FAIRNESS_EN
      chk("starve_if_gnt_seen", 32'(obs_if > 0), 32'h1);
`else
      chk("starve_no_if_gnt", 32'(obs_if), 32'h0);
`endif
      chk("starve_d_gnt_seen", 32'(obs_d >= 4), 32'h1);
      run(14);

      // Random traffic
      mode = 1;
      run(1500);
      mode = 0;
      run(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous memory between two requesters: the instruction-fetch port (if_*) and the load/store data port (d_*).
- Sits between the PC/fetch logic, the load/store path and a unified code+data RAM. This lets the CPU move from split instruction/data memories to one shared memory.
- Handles one transaction at a time. Sequencing is done by a small FSM and a latency counter.

Parameters:
- ADDR_W, 10, word address width (matches the pc[11:2] / alu_result[11:2] indexing).
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from memory issue to valid mem_rdata. Legal range is 1..7.
- STARVE_MAX, 4, number of consecutive fetch losses before fetch is forced to win. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted; 1-cycle pulse.
- if_rvalid  out  1  if_rdata valid; 1-cycle pulse.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted; 1-cycle pulse.
- d_rvalid  out  1  load data valid; 1-cycle pulse, loads only.
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All outputs go to 0, including the rdata holding registers.
  - The fairness counter clears.
  - Any in-flight transaction is dropped. No gnt or rvalid is produced for it, even if it was issued before reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, pick the winner and latch its owner, we, addr and wdata into registers. Next state is ISSUE.
  - Otherwise stay in IDLE.
  - A fetch winner is always a read (we = 0).
- Priority: data beats fetch when both are requested in the same cycle.
- ISSUE (exactly 1 cycle):
  - The winner's gnt is 1.
  - mem_en = 1 and mem_we = latched we. mem_addr and mem_wdata come from the latched registers.
  - Store: next state is IDLE. There is no rvalid for a store.
  - Load or fetch: load the counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register and go to IDLE.
  - The owner's rvalid is 1 in the following cycle, which is an IDLE cycle.
- Latency:
  - A read takes MEM_LAT+2 cycles from the req-sampled cycle to rvalid.
  - A store reaches the memory 1 cycle after the req-sampled cycle.
  - IDLE may arbitrate a new request in the same cycle that rvalid is high.
- Protocol:
  - A requester holds req, addr and data stable until it sees its gnt.
  - req is ignored outside IDLE, including during the gnt cycle itself.
  - Dropping req before gnt is a protocol violation. The arbiter still completes the transaction it latched.
- Output hold rules:
  - mem_addr and mem_wdata hold their last values between accesses.
  - mem_en and mem_we are 0 outside ISSUE.
  - if_rdata and d_rdata each hold until that port's next rvalid.
- Both rvalid signals are never high in the same cycle.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - A 3-bit counter increments each time data wins while if_req is also high.
  - When the counter equals STARVE_MAX, the next arbitration with if_req high goes to fetch, even if d_req is high.
  - The counter clears whenever fetch wins.
- Not defined: strict data-over-fetch priority, and the counter logic is absent.

Test Plan:
- Fetch read, MEM_LAT=1, mem[4]=0x20020005: if_req with if_addr=4 in cycle 0 -> cycle 1 has if_gnt=1, mem_en=1 and mem_addr=4; cycle 3 has if_rvalid=1 and if_rdata=0x20020005.
- Simultaneous requests in cycle 0, with d_we=1: d_gnt and mem_we in cycle 1, IDLE in cycle 2, if_gnt in cycle 3. Fetch completes normally afterwards.
- Store d_addr=0x10 / d_wdata=0xDEADBEEF, then load d_addr=0x10 -> d_rvalid=1 with d_rdata=0xDEADBEEF. No d_rvalid for the store.
- MEM_LAT=3 fetch -> busy is high in cycles 1..4 and if_rvalid arrives in cycle 5. if_rdata stays stable until the next fetch rvalid.
- rst pulsed during WAIT of a load -> all outputs read 0 immediately and d_rvalid never fires for that load. After release, a new fetch completes with the normal latency.
- d_req and if_req held high continuously for 20 cycles:
  - ARB_FAIRNESS_EN defined, STARVE_MAX=4: if_gnt after every 4 d_gnt.
  - ARB_FAIRNESS_EN not defined: no if_gnt at all.
